// File: rtl/ysyx_25020047_lsu_pkg.sv
// Shared types for the sequential load/store unit: FSM states, access size codes
// and the funct3 field layout.
package ysyx_25020047_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int F3_SIZE_LO = 0;
    localparam int F3_SIZE_HI = 1;
    localparam int F3_UNS     = 2;

    function automatic int unsigned size_bytes(input logic [1:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// Combinational lane steering: byte strobes and shifted store data for the bus,
// extracted and sign/zero-extended load data for the core.
module ysyx_25020047_lsu_align
    import ysyx_25020047_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                   size,
    input  logic                         uns,
    input  logic [$clog2(DATA_W/8)-1:0]  offset,
    input  logic [DATA_W-1:0]            wdata_raw,
    input  logic [DATA_W-1:0]            rdata_raw,
    output logic [DATA_W/8-1:0]          strb,
    output logic [DATA_W-1:0]            wdata_sh,
    output logic [DATA_W-1:0]            rdata_ext
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    logic [STRB_W-1:0] base;
    logic [DATA_W-1:0] shifted;
    logic [OFF_W+2:0]  sh_amt;
    int unsigned       nbytes;
    int                nbits;
    logic              sign;

    always_comb begin
        nbytes = size_bytes(size);
        nbits  = int'(nbytes) * 8;
        sh_amt = {offset, 3'b000};
        for (int i = 0; i < STRB_W; i++) begin
            base[i] = (i < int'(nbytes));
        end
        strb     = base << offset;
        wdata_sh = wdata_raw << sh_amt;
        shifted  = rdata_raw >> sh_amt;
        case (size)
            SZ_B:    sign = shifted[7];
            SZ_H:    sign = shifted[15];
            SZ_W:    sign = shifted[31];
            default: sign = shifted[DATA_W-1];
        endcase
        // Bits above the access width are filled with the extension bit; a full-width access passes through.
        for (int i = 0; i < DATA_W; i++) begin
            rdata_ext[i] = (i < nbits) ? shifted[i] : (sign & ~uns);
        end
    end

endmodule

// File: rtl/ysyx_25020047_lsu_seq.sv
// Multi-cycle load/store unit: one request at a time, one aligned bus transaction.
// YSYX_LSU_MISALIGN_TRAP_EN: fault misaligned accesses instead of aligning them down.
//
// state   | meaning
// IDLE    | ready for a core request
// REQ     | bus request presented, waiting for mem_req_ready
// WAIT    | waiting for bus response, timeout counter running
// RESP    | response presented, waiting for resp_ready
module ysyx_25020047_lsu_seq
    import ysyx_25020047_lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_W-1:0]    resp_rdata,
    output logic                 resp_err,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic [DATA_W/8-1:0]  mem_wstrb,
    input  logic                 mem_rsp_valid,
    input  logic [DATA_W-1:0]    mem_rsp_rdata,
    input  logic                 mem_rsp_err
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    lsu_state_e        state;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [OFF_W-1:0]  off_q;
    logic [CNT_W-1:0]  cnt;

    logic [1:0]        req_size;
    logic              req_uns;
    logic [OFF_W-1:0]  low_mask;
    logic [OFF_W-1:0]  eff_off;
    logic              illegal;
    logic              misalign;

    logic [1:0]        a_size;
    logic              a_uns;
    logic [OFF_W-1:0]  a_off;
    logic [STRB_W-1:0] a_strb;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;

    always_comb begin
        req_size = req_funct3[F3_SIZE_HI:F3_SIZE_LO];
        req_uns  = req_funct3[F3_UNS];
        low_mask = OFF_W'(size_bytes(req_size) - 1);
        illegal  = ((req_size == SZ_D) && (DATA_W == 32)) || (req_we && req_uns);
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
        misalign = (req_addr[OFF_W-1:0] & low_mask) != '0;
        eff_off  = req_addr[OFF_W-1:0];
`else
        misalign = 1'b0;
        eff_off  = req_addr[OFF_W-1:0] & ~low_mask;
`endif
        // Store data is steered from the live request; load data from the latched access.
        a_size = (state == ST_IDLE) ? req_size : size_q;
        a_uns  = (state == ST_IDLE) ? req_uns  : uns_q;
        a_off  = (state == ST_IDLE) ? eff_off  : off_q;
    end

    ysyx_25020047_lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size      (a_size),
        .uns       (a_uns),
        .offset    (a_off),
        .wdata_raw (req_wdata),
        .rdata_raw (mem_rsp_rdata),
        .strb      (a_strb),
        .wdata_sh  (a_wdata),
        .rdata_ext (a_rdata)
    );

    assign req_ready     = (state == ST_IDLE);
    assign resp_valid    = (state == ST_RESP);
    assign mem_req_valid = (state == ST_REQ);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            size_q     <= SZ_B;
            uns_q      <= 1'b0;
            off_q      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q   <= req_we;
                        size_q <= req_size;
                        uns_q  <= req_uns;
                        off_q  <= eff_off;
                        if (illegal || misalign) begin
                            state      <= ST_RESP;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ST_REQ;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata <= req_we ? a_wdata : '0;
                            mem_wstrb <= req_we ? a_strb : '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        state      <= ST_RESP;
                        resp_err   <= mem_rsp_err;
                        resp_rdata <= (we_q || mem_rsp_err) ? '0 : a_rdata;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state      <= ST_RESP;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020047_lsu_seq.sv
// Directed scoreboard bench for ysyx_25020047_lsu_seq (DATA_W=32, TIMEOUT=4).
module tb_ysyx_25020047_lsu_seq;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_rsp_valid = 1'b0;
    logic [DW-1:0] mem_rsp_rdata = '0;
    logic          mem_rsp_err = 1'b0;

    always #5 clk = ~clk;

    ysyx_25020047_lsu_seq #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_rdata"}, resp_rdata, 0);
        chk({tag, "_resp_err"}, resp_err, 0);
        chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after accept.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata);
        exp_t e;
        chk("issue_req_ready", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        e.err = exp_err; e.rdata = exp_rdata;
        sbq.push_back(e);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        chk("issue_accepted", req_ready, 0);
    endtask

    task automatic bus(input int rdy_dly, input logic exp_we, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input logic [3:0] exp_strb, input logic chk_wdata,
                       input logic [31:0] rsp_word, input logic rsp_err);
        for (int c = 0; c <= rdy_dly; c++) begin
            chk("mem_req_valid", mem_req_valid, 1);
            chk("mem_we", mem_we, exp_we);
            chk("mem_addr", mem_addr, exp_addr);
            if (chk_wdata) chk("mem_wdata", mem_wdata, exp_wdata);
            chk("mem_wstrb", mem_wstrb, exp_strb);
            chk("req_ready_busy", req_ready, 0);
            if (c == rdy_dly) mem_req_ready = 1'b1;
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        chk("mem_req_dropped", mem_req_valid, 0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = rsp_word; mem_rsp_err = rsp_err;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_rdata = '0;
    endtask

    task automatic resp(input int rdy_dly);
        exp_t e;
        chk("sb_nonempty", (sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            for (int c = 0; c <= rdy_dly; c++) begin
                chk("resp_valid", resp_valid, 1);
                chk("resp_err", resp_err, e.err);
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_req_ready", req_ready, 0);
                chk("resp_no_bus", mem_req_valid, 0);
                if (c == rdy_dly) resp_ready = 1'b1;
                @(negedge clk);
            end
            resp_ready = 1'b0;
            chk("resp_done", resp_valid, 0);
            chk("back_idle", req_ready, 1);
        end
    endtask

    initial begin
        int   k;
        exp_t drop;

        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_rel");

        // sb, minimum latency path
        issue(1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 0, 32'h0);
        bus(0, 1, 32'h8000_0000, 32'hAB00_0000, 4'h8, 1, 32'h0, 0);
        resp(0);

        // lh / lhu
        issue(0, 3'b001, 32'h8000_0002, 0, 0, 32'hFFFF_8001);
        bus(0, 0, 32'h8000_0000, 0, 4'h0, 0, 32'h8001_1234, 0);
        resp(0);
        issue(0, 3'b101, 32'h8000_0002, 0, 0, 32'h0000_8001);
        bus(0, 0, 32'h8000_0000, 0, 4'h0, 0, 32'h8001_1234, 0);
        resp(0);

        // lb / lbu / lw
        issue(0, 3'b000, 32'h8000_0001, 0, 0, 32'hFFFF_FF80);
        bus(0, 0, 32'h8000_0000, 0, 4'h0, 0, 32'h1234_80FE, 0);
        resp(0);
        issue(0, 3'b100, 32'h8000_0000, 0, 0, 32'h0000_00FE);
        bus(0, 0, 32'h8000_0000, 0, 4'h0, 0, 32'h1234_80FE, 0);
        resp(0);
        issue(0, 3'b010, 32'h8000_0004, 0, 0, 32'hDEAD_BEEF);
        bus(0, 0, 32'h8000_0004, 0, 4'h0, 0, 32'hDEAD_BEEF, 0);
        resp(0);

        // sh / sw
        issue(1, 3'b001, 32'h8000_0002, 32'h1234_5678, 0, 32'h0);
        bus(0, 1, 32'h8000_0000, 32'h5678_0000, 4'hC, 1, 32'h0, 0);
        resp(0);
        issue(1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 0, 32'h0);
        bus(0, 1, 32'h8000_0008, 32'hCAFE_F00D, 4'hF, 1, 32'h0, 0);
        resp(0);

        // misaligned accesses
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
        issue(0, 3'b010, 32'h8000_0001, 0, 1, 32'h0);
        resp(0);
        issue(0, 3'b001, 32'h8000_0003, 0, 1, 32'h0);
        resp(0);
`else
        issue(0, 3'b010, 32'h8000_0001, 0, 0, 32'h1122_3344);
        bus(0, 0, 32'h8000_0000, 0, 4'h0, 0, 32'h1122_3344, 0);
        resp(0);
        issue(0, 3'b001, 32'h8000_0003, 0, 0, 32'hFFFF_BEEF);
        bus(0, 0, 32'h8000_0000, 0, 4'h0, 0, 32'hBEEF_0000, 0);
        resp(0);
`endif

        // illegal: doubleword on 32-bit bus, unsigned store
        issue(0, 3'b011, 32'h8000_0000, 0, 1, 32'h0);
        resp(0);
        issue(1, 3'b100, 32'h8000_0000, 32'h55, 1, 32'h0);
        resp(0);

        // bus error
        issue(0, 3'b010, 32'h8000_0004, 0, 1, 32'h0);
        bus(0, 0, 32'h8000_0004, 0, 4'h0, 0, 32'h1234_5678, 1);
        resp(0);

        // backpressure on both handshakes
        issue(1, 3'b010, 32'h8000_000C, 32'hCAFE_F00D, 0, 32'h0);
        bus(3, 1, 32'h8000_000C, 32'hCAFE_F00D, 4'hF, 1, 32'h0, 0);
        resp(2);

        // timeout: response forced TO+1 cycles after the request handshake
        issue(0, 3'b010, 32'h8000_0010, 0, 1, 32'h0);
        chk("to_mem_req_valid", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        k = 1;
        while (resp_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_latency", k, TO + 1);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        resp(0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h6666_6666;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        chk("late_rsp_idle", req_ready, 1);
        chk("late_rsp_no_resp", resp_valid, 0);
        chk("late_rsp_no_bus", mem_req_valid, 0);

        // reset in WAIT drops the access
        issue(0, 3'b010, 32'h8000_0020, 0, 0, 32'h0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset_outputs("rst_wait");
        drop = sbq.pop_back();
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h7777_7777;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        chk("post_rst_no_resp", resp_valid, 0);
        chk("post_rst_idle", req_ready, 1);
        issue(0, 3'b100, 32'h8000_0002, 0, 0, 32'h0000_00AA);
        bus(0, 0, 32'h8000_0000, 0, 4'h0, 0, 32'h00AA_0000, 0);
        resp(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
